// File: rtl/scan_sel_if.sv
// Bundles the scan selector's control inputs and registered select outputs.
// The selector drives SEL/IDX/FRAME/BUSY; the user drives EN/MASK/DWELL.
interface scan_sel_if #(
   parameter int N_CH    = 4,
   parameter int DWELL_W = 16
);
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic               EN;
   logic [N_CH-1:0]    MASK;
   logic [DWELL_W-1:0] DWELL;
   logic [N_CH-1:0]    SEL;
   logic [IW-1:0]      IDX;
   logic               FRAME;
   logic               BUSY;

   modport master (output EN, MASK, DWELL, input SEL, IDX, FRAME, BUSY);
   modport slave  (input EN, MASK, DWELL, output SEL, IDX, FRAME, BUSY);
endinterface

// File: rtl/scan_sel.sv
// Round-robin one-hot channel scanner with per-channel mask, programmable dwell,
// an optional all-low blanking gap between channels and a pass-start FRAME pulse.
module scan_sel #(
   parameter int N_CH    = 4,
   parameter int DWELL_W = 16,
   parameter int BLANK   = 1
) (
   input logic       CLK,
   input logic       RST_N,
   scan_sel_if.slave bus
);
   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

   state_t             r_state;
   logic [N_CH-1:0]    r_sel;
   logic [IW-1:0]      r_idx;
   logic               r_frame;
   logic               r_busy;
   logic [DWELL_W-1:0] r_dwell_cnt;
   logic [BW-1:0]      r_blank_cnt;

   logic [IW-1:0]      w_low_idx;
   logic [IW-1:0]      w_next_idx;
   logic [IW-1:0]      w_pick_idx;
   logic               w_wrap;
   logic               w_any;
   logic               w_adv;
   logic               w_start;
   logic [DWELL_W-1:0] w_dwell_load;

   // Lowest set mask bit, and lowest set bit strictly above the current index.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_low_idx  = '0;
      w_next_idx = '0;
      w_wrap     = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (bus.MASK[i]) begin
            w_low_idx = IW'(i);
            if (i > int'(r_idx)) begin
               w_next_idx = IW'(i);
               w_wrap     = 1'b0;
            end
         end
      end
      if (w_wrap) w_next_idx = w_low_idx;
   end

   assign w_any        = |bus.MASK;
   assign w_start      = (r_state == S_IDLE);
   assign w_pick_idx   = w_start ? w_low_idx : w_next_idx;
   // Counter holds remaining cycles minus one, so a full-scale DWELL fits exactly.
   assign w_dwell_load = (bus.DWELL == '0) ? '0 : bus.DWELL - 1'b1;
   assign w_adv = ((r_state == S_ACTIVE) && (r_dwell_cnt == '0) && (BLANK == 0)) ||
                  ((r_state == S_BLANK) && (r_blank_cnt == '0));

   always_ff @(posedge CLK or negedge RST_N) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!RST_N) begin
         r_state     <= S_IDLE;
         r_sel       <= '0;
         r_idx       <= '0;
         r_frame     <= 1'b0;
         r_busy      <= 1'b0;
         r_dwell_cnt <= '0;
         r_blank_cnt <= '0;
      end else if (!bus.EN) begin
         r_state     <= S_IDLE;
         r_sel       <= '0;
         r_frame     <= 1'b0;
         r_busy      <= 1'b0;
         r_dwell_cnt <= '0;
         r_blank_cnt <= '0;
      end else if (w_start || w_adv) begin
         if (w_any) begin
            r_state     <= S_ACTIVE;
            r_idx       <= w_pick_idx;
            r_sel       <= N_CH'(1) << w_pick_idx;
            r_frame     <= w_start || w_wrap;
            r_busy      <= 1'b1;
            r_dwell_cnt <= w_dwell_load;
         end else begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
         end
      end else begin
         r_frame <= 1'b0;
         case (r_state)
            S_ACTIVE: begin
               if (r_dwell_cnt != '0) begin
                  r_dwell_cnt <= r_dwell_cnt - 1'b1;
               end else begin
                  // Only reachable with a non-zero gap; zero-gap ends take w_adv.
                  r_state     <= S_BLANK;
                  r_sel       <= '0;
                  r_blank_cnt <= BW'(BLANK - 1);
               end
            end
            S_BLANK:  r_blank_cnt <= r_blank_cnt - 1'b1;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.SEL   = r_sel;
   assign bus.IDX   = r_idx;
   assign bus.FRAME = r_frame;
   assign bus.BUSY  = r_busy;
endmodule

// File: tb/tb_scan_sel.sv
// Self-checking bench for scan_sel: four builds share one clock, and a
// segment-level reference model predicts SEL/IDX/FRAME/BUSY every cycle.
module tb_scan_sel;
   logic        CLK = 1'b0;
   logic        RST_N;
   logic        en;
   logic [3:0]  mask;
   logic [15:0] dwell;
   int          cur;

   always #5 CLK = ~CLK;

   // a: 4ch gap 1, b: 4ch no gap, c: 4ch gap 2, d: legacy 2ch no gap, 8-bit dwell
   scan_sel_if #(.N_CH(4), .DWELL_W(16)) if_a ();
   scan_sel_if #(.N_CH(4), .DWELL_W(16)) if_b ();
   scan_sel_if #(.N_CH(4), .DWELL_W(16)) if_c ();
   scan_sel_if #(.N_CH(2), .DWELL_W(8))  if_d ();

   assign if_a.EN = en && (cur == 0);
   assign if_b.EN = en && (cur == 1);
   assign if_c.EN = en && (cur == 2);
   assign if_d.EN = en && (cur == 3);
   assign if_a.MASK = mask;
   assign if_b.MASK = mask;
   assign if_c.MASK = mask;
   assign if_d.MASK = mask[1:0];
   assign if_a.DWELL = dwell;
   assign if_b.DWELL = dwell;
   assign if_c.DWELL = dwell;
   assign if_d.DWELL = dwell[7:0];

   scan_sel #(.N_CH(4), .DWELL_W(16), .BLANK(1)) u_a (.CLK(CLK), .RST_N(RST_N), .bus(if_a));
   scan_sel #(.N_CH(4), .DWELL_W(16), .BLANK(0)) u_b (.CLK(CLK), .RST_N(RST_N), .bus(if_b));
   scan_sel #(.N_CH(4), .DWELL_W(16), .BLANK(2)) u_c (.CLK(CLK), .RST_N(RST_N), .bus(if_c));
   scan_sel #(.N_CH(2), .DWELL_W(8),  .BLANK(0)) u_d (.CLK(CLK), .RST_N(RST_N), .bus(if_d));

   typedef struct packed {
      logic [3:0] sel;
      logic       frame;
   } ent_t;

   int         total;
   int         bad;
   int         n_ch;
   int         blank_len;
   bit         m_act;
   int         m_idx;
   ent_t       q[$];
   logic [3:0] exp_sel, obs_sel;
   logic [1:0] exp_idx, obs_idx;
   logic       exp_frame, obs_frame, exp_busy, obs_busy;

   task automatic select_dut(input int c);
      cur       = c;
      n_ch      = (c == 3) ? 2 : 4;
      blank_len = (c == 0) ? 1 : (c == 2) ? 2 : 0;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      en    = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
      q.delete();
      m_act = 1'b0;
      m_idx = 0;
      {exp_sel, exp_idx, exp_frame, exp_busy} = '0;
   endtask

   task automatic sample();
      case (cur)
         0: {obs_sel, obs_idx, obs_frame, obs_busy} = {if_a.SEL, if_a.IDX, if_a.FRAME, if_a.BUSY};
         1: {obs_sel, obs_idx, obs_frame, obs_busy} = {if_b.SEL, if_b.IDX, if_b.FRAME, if_b.BUSY};
         2: {obs_sel, obs_idx, obs_frame, obs_busy} = {if_c.SEL, if_c.IDX, if_c.FRAME, if_c.BUSY};
         default: {obs_sel, obs_idx, obs_frame, obs_busy} =
                  {2'b00, if_d.SEL, 1'b0, if_d.IDX, if_d.FRAME, if_d.BUSY};
      endcase
   endtask

   // One clock edge of the reference: whenever the current channel's schedule
   // runs out, plan the next channel as D select cycles followed by the gap.
   task automatic model_edge();
      logic [3:0] em;
      int         ed, d, ch;
      bit         wrap;
      ent_t       e;
      em = (n_ch == 2) ? {2'b00, mask[1:0]} : mask;
      ed = (cur == 3) ? int'(dwell[7:0]) : int'(dwell);
      if (!en) begin
         q.delete();
         m_act = 1'b0;
      end else if (q.size() == 0) begin
         if (em != 4'b0) begin
            ch = -1;
            if (m_act)
               for (int i = 0; i < n_ch; i++)
                  if (ch < 0 && em[i] && i > m_idx) ch = i;
            wrap = (ch < 0);
            if (wrap)
               for (int i = n_ch - 1; i >= 0; i--)
                  if (em[i]) ch = i;
            d = (ed == 0) ? 1 : ed;
            for (int k = 0; k < d; k++) q.push_back('{sel: 4'(1 << ch), frame: (k == 0) && wrap});
            for (int k = 0; k < blank_len; k++) q.push_back('{sel: 4'b0, frame: 1'b0});
            m_idx = ch;
            m_act = 1'b1;
         end else begin
            m_act = 1'b0;
         end
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         exp_sel   = e.sel;
         exp_frame = e.frame;
         exp_busy  = 1'b1;
      end else begin
         exp_sel   = 4'b0;
         exp_frame = 1'b0;
         exp_busy  = 1'b0;
      end
      exp_idx = 2'(m_idx);
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1 sample();
   endtask

   task automatic test_reset();
      select_dut(0);
      en    = 1'b1;
      mask  = 4'b1111;
      dwell = 16'd3;
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1 sample();
      total++;
      if ({obs_sel, obs_idx, obs_frame, obs_busy} !== 8'h00) begin
         bad++;
         $display("FAIL reset_state got=%h want=00", {obs_sel, obs_idx, obs_frame, obs_busy});
      end
   endtask

   task automatic test_start();
      logic [3:0] seq [16] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                              4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};
      select_dut(0);
      do_reset();
      mask  = 4'b1111;
      dwell = 16'd3;
      en    = 1'b1;
      for (int c = 0; c < 40; c++) begin
         step();
         total++;
         if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {exp_sel, exp_idx, exp_frame, exp_busy}) begin
            bad++;
            $display("FAIL start_model cyc=%0d got=%h want=%h", c,
                     {obs_sel, obs_idx, obs_frame, obs_busy}, {exp_sel, exp_idx, exp_frame, exp_busy});
         end
         total++;
         if ({obs_sel, obs_frame} !== {seq[c % 16], (c % 16) == 0}) begin
            bad++;
            $display("FAIL start_seq cyc=%0d got sel=%b frame=%b want sel=%b frame=%b",
                     c, obs_sel, obs_frame, seq[c % 16], (c % 16) == 0);
         end
      end
      step();  // first cycle of channel 2's dwell
      #2 RST_N = 1'b0;
      #1 sample();
      total++;
      if ({obs_sel, obs_idx, obs_busy} !== 7'h00) begin
         bad++;
         $display("FAIL async_reset got sel=%b idx=%0d busy=%b want 0", obs_sel, obs_idx, obs_busy);
      end
   endtask

   task automatic test_sparse();
      select_dut(0);
      do_reset();
      mask  = 4'b1010;
      dwell = 16'd2;
      en    = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step();
         total++;
         if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {exp_sel, exp_idx, exp_frame, exp_busy}) begin
            bad++;
            $display("FAIL sparse cyc=%0d got=%h want=%h", c,
                     {obs_sel, obs_idx, obs_frame, obs_busy}, {exp_sel, exp_idx, exp_frame, exp_busy});
         end
      end
   endtask

   task automatic test_single();
      for (int b = 1; b <= 2; b++) begin
         select_dut(b);
         do_reset();
         mask  = 4'b0100;
         dwell = 16'd0;
         en    = 1'b1;
         for (int c = 0; c < 15; c++) begin
            step();
            total++;
            if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {exp_sel, exp_idx, exp_frame, exp_busy}) begin
               bad++;
               $display("FAIL single_b%0d cyc=%0d got=%h want=%h", b, c,
                        {obs_sel, obs_idx, obs_frame, obs_busy}, {exp_sel, exp_idx, exp_frame, exp_busy});
            end
         end
      end
   endtask

   task automatic test_mid_changes();
      select_dut(0);
      do_reset();
      mask  = 4'b1111;
      dwell = 16'd3;
      en    = 1'b1;
      for (int c = 0; c < 60; c++) begin
         case (c)
            2:  mask  = 4'b1110;  // drop channel 0 during its own dwell
            9:  dwell = 16'd5;    // mid-dwell on channel 2
            40: mask  = 4'b0000;
            default: ;
         endcase
         step();
         total++;
         if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {exp_sel, exp_idx, exp_frame, exp_busy}) begin
            bad++;
            $display("FAIL mid_change cyc=%0d got=%h want=%h", c,
                     {obs_sel, obs_idx, obs_frame, obs_busy}, {exp_sel, exp_idx, exp_frame, exp_busy});
         end
      end
      total++;
      if ({obs_sel, obs_busy} !== 5'b0) begin
         bad++;
         $display("FAIL mask_zero_idle got sel=%b busy=%b want 0", obs_sel, obs_busy);
      end
   endtask

   task automatic test_en_toggle();
      bit found = 1'b0;
      select_dut(0);
      do_reset();
      mask  = 4'b1111;
      dwell = 16'd3;
      en    = 1'b1;
      for (int c = 0; c < 60 && !found; c++) begin
         step();
         total++;
         if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {exp_sel, exp_idx, exp_frame, exp_busy}) begin
            bad++;
            $display("FAIL en_run cyc=%0d got=%h want=%h", c,
                     {obs_sel, obs_idx, obs_frame, obs_busy}, {exp_sel, exp_idx, exp_frame, exp_busy});
         end
         found = (exp_sel == 4'b0100);
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL en_wait_ch2 got=timeout want=channel 2 within 60 cycles");
      end
      step();
      en = 1'b0;
      step();
      total++;
      if ({obs_sel, obs_frame, obs_busy} !== 6'b0) begin
         bad++;
         $display("FAIL en_drop got sel=%b frame=%b busy=%b want 0", obs_sel, obs_frame, obs_busy);
      end
      en = 1'b1;
      step();
      total++;
      if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {4'b0001, 2'd0, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL en_restart got=%h want=%h", {obs_sel, obs_idx, obs_frame, obs_busy},
                  {4'b0001, 2'd0, 1'b1, 1'b1});
      end
   endtask

   task automatic test_legacy();
      int cnt0 = 0;
      int cnt1 = 0;
      select_dut(3);
      do_reset();
      mask  = 4'b0011;
      dwell = 16'd1;
      en    = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         total++;
         if ({obs_sel, obs_frame} !== {((c % 2) == 0) ? 4'b0001 : 4'b0010, (c % 2) == 0}) begin
            bad++;
            $display("FAIL legacy_alt cyc=%0d got sel=%b frame=%b", c, obs_sel, obs_frame);
         end
      end
      do_reset();
      mask  = 4'b0011;
      dwell = 16'h00FF;
      en    = 1'b1;
      for (int c = 0; c < 600; c++) begin
         step();
         if (c < 510) begin
            if (obs_sel == 4'b0001) cnt0++;
            if (obs_sel == 4'b0010) cnt1++;
         end
         total++;
         if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {exp_sel, exp_idx, exp_frame, exp_busy}) begin
            bad++;
            $display("FAIL legacy_max cyc=%0d got=%h want=%h", c,
                     {obs_sel, obs_idx, obs_frame, obs_busy}, {exp_sel, exp_idx, exp_frame, exp_busy});
         end
      end
      total++;
      if (cnt0 != 255 || cnt1 != 255) begin
         bad++;
         $display("FAIL max_dwell_len got=%0d/%0d want=255/255", cnt0, cnt1);
      end
   endtask

   task automatic test_random();
      for (int b = 0; b < 3; b++) begin
         select_dut(b);
         do_reset();
         mask  = 4'($urandom_range(1, 15));
         dwell = 16'($urandom_range(0, 4));
         en    = 1'b1;
         for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) mask  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) dwell = 16'($urandom_range(0, 4));
            if ($urandom_range(0, 49) == 0) en    = ~en;
            step();
            total++;
            if ({obs_sel, obs_idx, obs_frame, obs_busy} !== {exp_sel, exp_idx, exp_frame, exp_busy}) begin
               bad++;
               $display("FAIL random_b%0d cyc=%0d got=%h want=%h", b, c,
                        {obs_sel, obs_idx, obs_frame, obs_busy}, {exp_sel, exp_idx, exp_frame, exp_busy});
            end
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      RST_N = 1'b0;
      en    = 1'b0;
      mask  = 4'b0;
      dwell = 16'd0;
      select_dut(0);
      test_reset();
      test_start();
      test_sparse();
      test_single();
      test_mid_changes();
      test_en_toggle();
      test_legacy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=bench completion");
      $fatal(1, "watchdog expired");
   end
endmodule
